// File: rtl/axi_pkg.sv
// Shared AXI4 burst types, protocol constants and burst-geometry helpers
// for the cache-block burst master.
package axi_pkg;

    localparam int AXI_AW = 64;
    localparam int AXI_DW = 64;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    typedef struct packed {
        logic [AXI_AW-1:0] addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
    } axi_ax_t;

    typedef struct packed {
        logic [AXI_DW-1:0]   data;
        logic [AXI_DW/8-1:0] strb;
        logic                last;
    } axi_w_t;

    typedef struct packed {
        logic [AXI_DW-1:0] data;
        logic [1:0]        resp;
        logic              last;
    } axi_r_t;

    typedef enum logic [2:0] {
        IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP, DONE
    } burst_state_t;

    function automatic int beats_of(input int block_w, input int data_w);
        return block_w / data_w;
    endfunction

    function automatic int size_of(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/axi_beat_counter.sv
// Beat index within one burst: advances per data handshake, flags the final
// beat and wraps to zero after it. Shared by the read and write data paths.
module axi_beat_counter #(
    parameter  int BEATS = 8,
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o,
    output logic             last_o
);

    logic [CNT_W-1:0] count_q, count_d;

    assign count_o = count_q;
    assign last_o  = (count_q == CNT_W'(BEATS - 1));

    always_comb begin
        // NOTE: next-state gets a default first so no path leaves it unassigned (no latch).
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = last_o ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking so every register samples pre-edge values.
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end

endmodule

// File: rtl/axi_burst_master.sv
// Cache-block <-> AXI4 INCR burst engine: write-back and refill bursts.
// Optional macro AXI_RESP_CHECK_EN adds a sticky o_axi_err response checker.
module axi_burst_master
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH  = AXI_AW,
    parameter int BLOCK_WIDTH = 512,
    parameter int AXI_DATA_W  = AXI_DW
) (
    input  logic                   i_clk,
    input  logic                   i_arst,
    input  logic                   i_start_read,
    input  logic                   i_start_write,
    input  logic [ADDR_WIDTH-1:0]  i_addr,
    input  logic [BLOCK_WIDTH-1:0] i_data_block,
    output logic                   o_done,
    output logic [BLOCK_WIDTH-1:0] o_data_block,
    output axi_ax_t                o_aw,
    output logic                   o_awvalid,
    input  logic                   i_awready,
    output axi_w_t                 o_w,
    output logic                   o_wvalid,
    input  logic                   i_wready,
    input  logic [1:0]             i_bresp,
    input  logic                   i_bvalid,
    output logic                   o_bready,
    output axi_ax_t                o_ar,
    output logic                   o_arvalid,
    input  logic                   i_arready,
    input  axi_r_t                 i_r,
    input  logic                   i_rvalid,
    output logic                   o_rready
`ifdef AXI_RESP_CHECK_EN
    ,
    output logic                   o_axi_err
`endif
);

    localparam int BEATS = beats_of(BLOCK_WIDTH, AXI_DATA_W);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFF_W = $clog2(BLOCK_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
        {{(ADDR_WIDTH - OFF_W){1'b1}}, {OFF_W{1'b0}}};

    burst_state_t           state_q, state_d;
    axi_ax_t                aw_q, aw_d, ar_q, ar_d, ax_req;
    logic [BLOCK_WIDTH-1:0] wblock_q, wblock_d, rblock_q, rblock_d;
    logic [CNT_W-1:0]       beat_cnt;
    logic                   beat_last, beat_inc;

    assign ax_req = '{addr:  AXI_AW'(i_addr & ALIGN_MASK),
                      len:   8'(BEATS - 1),
                      size:  3'(size_of(AXI_DATA_W)),
                      burst: BURST_INCR};

    assign beat_inc = (state_q == RD_DATA && i_rvalid) || (state_q == WR_DATA && i_wready);

    axi_beat_counter #(.BEATS(BEATS)) u_beat_cnt (
        .clk     (i_clk),
        .rst_n   (i_arst),
        .clr_i   (state_q == IDLE),
        .inc_i   (beat_inc),
        .count_o (beat_cnt),
        .last_o  (beat_last)
    );

    always_comb begin
        state_d   = state_q;
        aw_d      = aw_q;
        ar_d      = ar_q;
        wblock_d  = wblock_q;
        rblock_d  = rblock_q;
        o_awvalid = 1'b0;
        o_wvalid  = 1'b0;
        o_bready  = 1'b0;
        o_arvalid = 1'b0;
        o_rready  = 1'b0;
        o_done    = 1'b0;
        o_w       = '0;
        unique case (state_q)
            IDLE: begin
                // Dirty eviction must land before the refill that replaces it.
                if (i_start_write) begin
                    aw_d     = ax_req;
                    wblock_d = i_data_block;
                    state_d  = WR_ADDR;
                end else if (i_start_read) begin
                    ar_d    = ax_req;
                    state_d = RD_ADDR;
                end
            end
            RD_ADDR: begin
                o_arvalid = 1'b1;
                if (i_arready) state_d = RD_DATA;
            end
            RD_DATA: begin
                o_rready = 1'b1;
                if (i_rvalid) begin
                    rblock_d[int'(beat_cnt)*AXI_DATA_W +: AXI_DATA_W] = i_r.data;
                    if (beat_last) state_d = DONE;
                end
            end
            WR_ADDR: begin
                o_awvalid = 1'b1;
                if (i_awready) state_d = WR_DATA;
            end
            WR_DATA: begin
                o_wvalid = 1'b1;
                o_w.data = wblock_q[int'(beat_cnt)*AXI_DATA_W +: AXI_DATA_W];
                o_w.strb = '1;
                o_w.last = beat_last;
                if (i_wready && beat_last) state_d = WR_RESP;
            end
            WR_RESP: begin
                o_bready = 1'b1;
                if (i_bvalid) state_d = DONE;
            end
            DONE: begin
                o_done  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            state_q  <= IDLE;
            aw_q     <= '0;
            ar_q     <= '0;
            // NOTE: block buffers are reset so no X can ever reach o_w or o_data_block.
            wblock_q <= '0;
            rblock_q <= '0;
        end else begin
            state_q  <= state_d;
            aw_q     <= aw_d;
            ar_q     <= ar_d;
            wblock_q <= wblock_d;
            rblock_q <= rblock_d;
        end
    end

    assign o_aw         = aw_q;
    assign o_ar         = ar_q;
    assign o_data_block = rblock_q;

`ifdef AXI_RESP_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (state_q == RD_DATA && i_rvalid &&
            (i_r.resp != RESP_OKAY || i_r.last != beat_last)) err_d = 1'b1;
        if (state_q == WR_RESP && i_bvalid && i_bresp != RESP_OKAY) err_d = 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) err_q <= 1'b0;
        else         err_q <= err_d;
    end

    assign o_axi_err = err_q;
`else
    logic unused_resp;
    assign unused_resp = ^{i_bresp, i_r.resp, i_r.last};
`endif

endmodule

// File: tb/tb_axi_burst_master.sv
// Scoreboard bench for axi_burst_master: an AXI slave model feeds the DUT,
// expectations are queued at issue time and a monitor pops them on handshakes.
module tb_axi_burst_master;
    import axi_pkg::*;

    localparam int BEATS = 8;
    localparam int DW    = 64;
    localparam int BW    = 512;
    localparam int AW    = 64;

    logic          clk = 1'b0;
    logic          i_arst, i_start_read, i_start_write;
    logic [AW-1:0] i_addr;
    logic [BW-1:0] i_data_block, o_data_block;
    logic          o_done;
    axi_ax_t       o_aw, o_ar;
    axi_w_t        o_w;
    axi_r_t        i_r;
    logic          o_awvalid, i_awready, o_wvalid, i_wready, i_bvalid, o_bready;
    logic          o_arvalid, i_arready, i_rvalid, o_rready;
    logic [1:0]    i_bresp;
`ifdef AXI_RESP_CHECK_EN
    logic          o_axi_err;
`endif

    always #5 clk = ~clk;

    axi_burst_master dut (
        .i_clk(clk), .i_arst(i_arst),
        .i_start_read(i_start_read), .i_start_write(i_start_write),
        .i_addr(i_addr), .i_data_block(i_data_block),
        .o_done(o_done), .o_data_block(o_data_block),
        .o_aw(o_aw), .o_awvalid(o_awvalid), .i_awready(i_awready),
        .o_w(o_w), .o_wvalid(o_wvalid), .i_wready(i_wready),
        .i_bresp(i_bresp), .i_bvalid(i_bvalid), .o_bready(o_bready),
        .o_ar(o_ar), .o_arvalid(o_arvalid), .i_arready(i_arready),
        .i_r(i_r), .i_rvalid(i_rvalid), .o_rready(o_rready)
`ifdef AXI_RESP_CHECK_EN
        , .o_axi_err(o_axi_err)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_event(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event occurred, none expected", name);
    endtask

    // Scoreboard queues and the reference model of the last refilled block
    axi_ax_t       exp_ar_q[$], exp_aw_q[$];
    axi_w_t        exp_w_q[$];
    logic [BW-1:0] exp_done_q[$];
    logic [BW-1:0] last_block = '0;
    int            r_hs_count = 0;

    // Slave model configuration
    logic [DW-1:0] rd_mem[BEATS];
    bit rand_mode  = 0;
    int stall_beat = -1;
    int stall_left = 0;
    int rerr_beat  = -1;

    // Monitor
    initial begin
        bit     stall_prev = 0;
        axi_w_t w_prev;
        forever begin
            @(negedge clk);
            if (!i_arst) begin
                stall_prev = 0;
                continue;
            end
            if (o_arvalid && i_arready) begin
                if (exp_ar_q.size() == 0) fail_event("ar_unexpected");
                else check("ar_fields", o_ar, exp_ar_q.pop_front());
            end
            if (o_awvalid && i_awready) begin
                if (exp_aw_q.size() == 0) fail_event("aw_unexpected");
                else check("aw_fields", o_aw, exp_aw_q.pop_front());
            end
            if (stall_prev) check("w_stable", o_w, w_prev);
            if (o_wvalid && i_wready) begin
                if (exp_w_q.size() == 0) fail_event("w_unexpected");
                else check("w_beat", o_w, exp_w_q.pop_front());
            end
            stall_prev = o_wvalid && !i_wready;
            w_prev     = o_w;
            if (o_rready && i_rvalid) r_hs_count++;
            if (o_done) begin
                if (exp_done_q.size() == 0) fail_event("done_unexpected");
                else check("done_block", o_data_block, exp_done_q.pop_front());
            end
        end
    end

    // AXI slave model
    initial begin
        bit ar_hs, r_hs, w_hs, b_hs, rd_pend, b_pend;
        int rd_k, w_cnt;
        rd_pend = 0; b_pend = 0; rd_k = 0; w_cnt = 0;
        i_arready = 0; i_awready = 0; i_wready = 0; i_rvalid = 0;
        i_bvalid = 0; i_bresp = 2'b00; i_r = '0;
        forever begin
            @(negedge clk);
            ar_hs = o_arvalid && i_arready;
            r_hs  = o_rready && i_rvalid;
            w_hs  = o_wvalid && i_wready;
            b_hs  = o_bready && i_bvalid;
            @(posedge clk);
            #1;
            if (!i_arst) begin
                rd_pend = 0; b_pend = 0; rd_k = 0; w_cnt = 0;
                i_arready = 0; i_awready = 0; i_wready = 0; i_rvalid = 0;
                i_bvalid = 0; i_r = '0;
                continue;
            end
            if (ar_hs) begin rd_pend = 1; rd_k = 0; end
            if (r_hs) begin
                rd_k++;
                if (rd_k == BEATS) rd_pend = 0;
            end
            if (w_hs) begin
                w_cnt++;
                if (w_cnt == BEATS) begin b_pend = 1; w_cnt = 0; end
            end
            if (b_hs) b_pend = 0;
            i_arready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            i_awready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            i_rvalid  = rd_pend && (rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1);
            i_r.data  = rd_pend ? rd_mem[rd_k] : '0;
            i_r.last  = rd_pend && (rd_k == BEATS - 1);
            i_r.resp  = (rd_pend && rd_k == rerr_beat) ? 2'b10 : RESP_OKAY;
            if (o_wvalid && w_cnt == stall_beat && stall_left > 0) begin
                i_wready = 1'b0;
                stall_left--;
            end else begin
                i_wready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            i_bvalid = b_pend && (rand_mode ? ($urandom_range(0, 1) != 0) : 1'b1);
            i_bresp  = RESP_OKAY;
        end
    end

    function automatic axi_ax_t exp_ax(input logic [AW-1:0] addr);
        exp_ax = '{addr: {addr[AW-1:6], 6'd0}, len: 8'd7, size: 3'd3, burst: 2'b01};
    endfunction

    task automatic queue_write(input logic [AW-1:0] addr, input logic [BW-1:0] blk);
        exp_aw_q.push_back(exp_ax(addr));
        for (int k = 0; k < BEATS; k++)
            exp_w_q.push_back('{data: blk[k*DW +: DW], strb: 8'hFF, last: (k == BEATS - 1)});
        exp_done_q.push_back(last_block);
    endtask

    task automatic queue_read(input logic [AW-1:0] addr);
        logic [BW-1:0] blk;
        for (int k = 0; k < BEATS; k++) blk[k*DW +: DW] = rd_mem[k];
        exp_ar_q.push_back(exp_ax(addr));
        last_block = blk;
        exp_done_q.push_back(blk);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        @(negedge clk);
        while (!o_done && lat < 400) begin
            lat++;
            @(negedge clk);
        end
        if (!o_done) fail_event("done_timeout");
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic random_mem();
        for (int k = 0; k < BEATS; k++) rd_mem[k] = {$urandom, $urandom};
    endtask

    function automatic logic [BW-1:0] random_block();
        logic [BW-1:0] b;
        for (int k = 0; k < BW / 32; k++) b[k*32 +: 32] = $urandom;
        return b;
    endfunction

    // Stimulus
    initial begin
        int            lat;
        logic [AW-1:0] addr;
        logic [BW-1:0] blk;

        i_arst = 1'b0; i_start_read = 0; i_start_write = 0;
        i_addr = '0; i_data_block = '0;
        #3;
        check("reset_ctrl", {o_done, o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready}, '0);
        check("reset_data_block", o_data_block, '0);
        check("reset_ax", {o_aw, o_ar, o_w}, '0);
        repeat (2) step();
        i_arst = 1'b1;
        step();

        // Zero-wait refill from a fixed address
        for (int k = 0; k < BEATS; k++) rd_mem[k] = 64'(k);
        addr = 64'h1234;
        queue_read(addr);
        i_addr = addr; i_start_read = 1;
        wait_done(lat);
        check("read_latency", lat, 10);
        step(); i_start_read = 0;
        step();

        // Write-back with two cycles of W backpressure on beat 3
        blk = random_block();
        addr = {$urandom, $urandom};
        queue_write(addr, blk);
        stall_beat = 3; stall_left = 2;
        i_addr = addr; i_data_block = blk; i_start_write = 1;
        wait_done(lat);
        check("write_stall_latency", lat, BEATS + 3 + 2);
        step(); i_start_write = 0; stall_beat = -1;
        step();

        // Both requests together: eviction first, then refill
        blk = random_block();
        random_mem();
        addr = {$urandom, $urandom};
        queue_write(addr, blk);
        queue_read(addr);
        i_addr = addr; i_data_block = blk; i_start_write = 1; i_start_read = 1;
        wait_done(lat);
        step(); i_start_write = 0;
        wait_done(lat);
        step(); i_start_read = 0;
        step();

        // Randomized traffic with random handshakes on every channel
        rand_mode = 1;
        for (int t = 0; t < 16; t++) begin
            addr = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) begin
                blk = random_block();
                queue_write(addr, blk);
                i_addr = addr; i_data_block = blk; i_start_write = 1;
            end else begin
                random_mem();
                queue_read(addr);
                i_addr = addr; i_start_read = 1;
            end
            wait_done(lat);
            step(); i_start_write = 0; i_start_read = 0;
            step();
        end
        rand_mode = 0;

        // Reset during read beat 4
        random_mem();
        begin
            int base;
            int budget;
            base = r_hs_count;
            budget = 0;
            queue_read(64'h8000);
            i_addr = 64'h8000; i_start_read = 1;
            while (r_hs_count - base < 4 && budget < 100) begin
                @(negedge clk);
                budget++;
            end
            if (r_hs_count - base < 4) fail_event("reset_beat_timeout");
        end
        @(posedge clk);
        #3;
        i_arst = 1'b0;
        #1;
        check("midreset_ctrl", {o_done, o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready}, '0);
        check("midreset_data_block", o_data_block, '0);
        check("midreset_ax", {o_aw, o_ar, o_w}, '0);
        exp_done_q.delete();
        exp_ar_q.delete();
        last_block = '0;
        i_start_read = 0;
        repeat (2) step();
        i_arst = 1'b1;
        step();
        random_mem();
        queue_read(64'h8040);
        i_addr = 64'h8040; i_start_read = 1;
        wait_done(lat);
        check("post_reset_read_latency", lat, 10);
        step(); i_start_read = 0;
        step();

`ifdef AXI_RESP_CHECK_EN
        check("err_clean", o_axi_err, 1'b0);
        random_mem();
        rerr_beat = 2;
        queue_read(64'h100);
        i_addr = 64'h100; i_start_read = 1;
        wait_done(lat);
        step(); i_start_read = 0; rerr_beat = -1;
        check("err_set_slverr", o_axi_err, 1'b1);
        blk = random_block();
        queue_write(64'h200, blk);
        i_addr = 64'h200; i_data_block = blk; i_start_write = 1;
        wait_done(lat);
        step(); i_start_write = 0;
        step();
        check("err_sticky", o_axi_err, 1'b1);
`endif

        repeat (4) step();
        check("queues_drained",
              exp_ar_q.size() + exp_aw_q.size() + exp_w_q.size() + exp_done_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
